// File: rtl/cam_seq_pkg.sv
// Shared definitions for the OV5640 power-up sequencer: state encoding,
// default timing at 50 MHz and the pin decode for each state.
package cam_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HOLD     = 3'd1,
        PWDN_REL = 3'd2,
        BOOT     = 3'd3,
        CFG      = 3'd4,
        RUN      = 3'd5,
        FAULT    = 3'd6
    } state_t;

    localparam int T_HOLD_DEF      = 250000;
    localparam int T_PWDN_REL_DEF  = 50000;
    localparam int T_BOOT_DEF      = 1000000;
    localparam int CFG_TIMEOUT_DEF = 5000000;
    localparam int LOCK_FILT_DEF   = 16;
    localparam int MAX_RETRY_DEF   = 3;
    localparam int CNT_W_DEF       = 24;

    // Camera held powered down whenever the sensor is not being brought up or used.
    function automatic logic pwdn_of(input state_t s);
        return (s == IDLE) || (s == HOLD) || (s == FAULT);
    endfunction

    function automatic logic rstn_of(input state_t s);
        return (s == BOOT) || (s == CFG) || (s == RUN);
    endfunction

endpackage

// File: rtl/cam_power_seq_if.sv
// Camera pin, SCCB handshake and status bundle of the power sequencer.
interface cam_power_seq_if;

    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       cfg_start;
    logic       cfg_done;
    logic       sys_ready;
    logic       fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;

    modport master (
        output cam_pwdn, cam_rst_n, cfg_start, sys_ready, fault, state, retry_cnt,
        input  cfg_done
    );

    modport slave (
        input  cam_pwdn, cam_rst_n, cfg_start, sys_ready, fault, state, retry_cnt,
        output cfg_done
    );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter; zero is high while the count reads 0.
module seq_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cam_power_seq.sv
// OV5640 power-up / recovery sequencer: lock qualification, PWDN/RESET timing,
// SCCB configuration supervision with bounded retries.
module cam_power_seq
    import cam_seq_pkg::*;
#(
    parameter int T_HOLD      = T_HOLD_DEF,
    parameter int T_PWDN_REL  = T_PWDN_REL_DEF,
    parameter int T_BOOT      = T_BOOT_DEF,
    parameter int CFG_TIMEOUT = CFG_TIMEOUT_DEF,
    parameter int LOCK_FILT   = LOCK_FILT_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              restart,
    cam_power_seq_if.master   bus
);

    // state    | meaning
    // IDLE     | powered down, waiting for qualified lock
    // HOLD     | PWDN=1, RESET low for T_HOLD
    // PWDN_REL | PWDN=0, RESET low for T_PWDN_REL
    // BOOT     | RESET released, T_BOOT before configuration
    // CFG      | SCCB configuration running, timeout supervised
    // RUN      | camera path ready
    // FAULT    | retries exhausted, powered down until restart

    localparam int FILT_W = $clog2(LOCK_FILT + 1);

    logic              lock_m, lock_s, lock_q;
    logic [FILT_W-1:0] filt_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_m   <= 1'b0;
            lock_s   <= 1'b0;
            filt_cnt <= '0;
            lock_q   <= 1'b0;
        end else begin
            lock_m <= pll_locked;
            lock_s <= lock_m;
            if (!lock_s) begin
                filt_cnt <= '0;
                lock_q   <= 1'b0;
            end else if (filt_cnt == FILT_W'(LOCK_FILT)) begin
                lock_q <= 1'b1;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    state_t           state_r, state_nxt;
    logic [1:0]       retry_r, retry_nxt;
    logic             tmr_load, tmr_zero, to_load, to_zero;
    logic [CNT_W-1:0] tmr_val;
    logic             cam_pwdn_r, cam_rst_n_r, cfg_start_r, sys_ready_r, fault_r;

    seq_timer #(.CNT_W(CNT_W)) u_state_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    seq_timer #(.CNT_W(CNT_W)) u_cfg_tmr (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (to_load),
        .load_val (CNT_W'(CFG_TIMEOUT - 1)),
        .zero     (to_zero)
    );

    always_comb begin
        state_nxt = state_r;
        retry_nxt = retry_r;
        // Only IDLE can legitimately see lock_q low, so a low level elsewhere is a fall.
        if (!lock_q && state_r != IDLE) begin
            state_nxt = IDLE;
        end else if (restart) begin
            state_nxt = IDLE;
            retry_nxt = '0;
        end else begin
            case (state_r)
                IDLE:     if (lock_q)   state_nxt = HOLD;
                HOLD:     if (tmr_zero) state_nxt = PWDN_REL;
                PWDN_REL: if (tmr_zero) state_nxt = BOOT;
                BOOT:     if (tmr_zero) state_nxt = CFG;
                CFG: begin
                    // cfg_start_r marks the entry cycle, where cfg_done is ignored.
                    if (bus.cfg_done && !cfg_start_r) begin
                        state_nxt = RUN;
                        retry_nxt = '0;
                    end else if (to_zero) begin
                        retry_nxt = retry_r + 1'b1;
                        state_nxt = (retry_nxt == 2'(MAX_RETRY)) ? FAULT : HOLD;
                    end
                end
                RUN:      state_nxt = RUN;
                FAULT:    state_nxt = FAULT;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        to_load  = 1'b0;
        if (state_nxt != state_r) begin
            case (state_nxt)
                HOLD:     begin tmr_load = 1'b1; tmr_val = CNT_W'(T_HOLD - 1);     end
                PWDN_REL: begin tmr_load = 1'b1; tmr_val = CNT_W'(T_PWDN_REL - 1); end
                BOOT:     begin tmr_load = 1'b1; tmr_val = CNT_W'(T_BOOT - 1);     end
                CFG:      to_load = 1'b1;
                default:  tmr_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            retry_r     <= '0;
            cam_pwdn_r  <= 1'b1;
            cam_rst_n_r <= 1'b0;
            cfg_start_r <= 1'b0;
            sys_ready_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            retry_r     <= retry_nxt;
            cam_pwdn_r  <= pwdn_of(state_nxt);
            cam_rst_n_r <= rstn_of(state_nxt);
            cfg_start_r <= (state_nxt == CFG) && (state_r != CFG);
            sys_ready_r <= (state_nxt == RUN);
            fault_r     <= (state_nxt == FAULT);
        end
    end

    assign bus.cam_pwdn  = cam_pwdn_r;
    assign bus.cam_rst_n = cam_rst_n_r;
    assign bus.cfg_start = cfg_start_r;
    assign bus.sys_ready = sys_ready_r;
    assign bus.fault     = fault_r;
    assign bus.state     = state_r;
    assign bus.retry_cnt = retry_r;

endmodule
